// File: rtl/painterengine_gpu_dma_pkg.sv
// rtl/painterengine_gpu_dma_pkg.sv - shared FSM state and error codes for the GPU DMA reader/writer
package painterengine_gpu_dma_pkg;

    typedef enum logic [2:0] {
        ST_ROUTING       = 3'd0,
        ST_PARAM_CHECK   = 3'd1,
        ST_CALC_ADDRESS  = 3'd2,
        ST_ADDRESS_WRITE = 3'd3,
        ST_DATA_WRITE    = 3'd4,
        ST_RESPONSE      = 3'd5,
        ST_DONE          = 3'd6,
        ST_ERROR         = 3'd7
    } dma_state_t;

    localparam logic [2:0] ERR_NONE       = 3'b000;
    localparam logic [2:0] ERR_ROUTER     = 3'b001;
    localparam logic [2:0] ERR_ADDRESS    = 3'b010;
    localparam logic [2:0] ERR_AW_TIMEOUT = 3'b011;
    localparam logic [2:0] ERR_W_TIMEOUT  = 3'b100;
    localparam logic [2:0] ERR_PROTOCOL   = 3'b101;
    localparam logic [2:0] ERR_B_TIMEOUT  = 3'b110;

    // Beats for the next burst: whatever remains, clipped so the burst stops at the 1 KB page end.
    function automatic logic [8:0] calc_burst(input logic [31:0] address,
                                              input logic [31:0] length,
                                              input logic [31:0] offset);
        logic [31:0] remaining;
        logic [7:0]  word_pos;
        logic [8:0]  boundary;
        remaining = length - offset;
        word_pos  = address[9:2] + offset[7:0];
        boundary  = 9'd256 - {1'b0, word_pos};
        return (remaining < {23'd0, boundary}) ? remaining[8:0] : boundary;
    endfunction

endpackage

// File: rtl/painterengine_gpu_dma_writer.sv
// rtl/painterengine_gpu_dma_writer.sv - four-slot routed AXI write DMA with 1 KB burst splitting
module painterengine_gpu_dma_writer
    import painterengine_gpu_dma_pkg::*;
#(
    parameter int TIMEOUT_BIT = 18
) (
    input  logic         i_wire_clock,
    input  logic         i_wire_reset,
    input  logic [127:0] i_wire_address,
    input  logic [127:0] i_wire_length,
    input  logic [3:0]   i_wire_router,
    input  logic [127:0] i_wire_data,
    input  logic [3:0]   i_wire_data_valid,
    output logic [3:0]   o_wire_data_next,
    output logic         o_wire_done,
    output logic         o_wire_error,
    output logic [2:0]   o_wire_error_type,
    output logic         o_wire_M_AXI_AWID,
    output logic [31:0]  o_wire_M_AXI_AWADDR,
    output logic [7:0]   o_wire_M_AXI_AWLEN,
    output logic [2:0]   o_wire_M_AXI_AWSIZE,
    output logic [1:0]   o_wire_M_AXI_AWBURST,
    output logic         o_wire_M_AXI_AWLOCK,
    output logic [3:0]   o_wire_M_AXI_AWCACHE,
    output logic [2:0]   o_wire_M_AXI_AWPROT,
    output logic [3:0]   o_wire_M_AXI_AWQOS,
    output logic         o_wire_M_AXI_AWVALID,
    input  logic         i_wire_M_AXI_AWREADY,
    output logic [31:0]  o_wire_M_AXI_WDATA,
    output logic [3:0]   o_wire_M_AXI_WSTRB,
    output logic         o_wire_M_AXI_WLAST,
    output logic         o_wire_M_AXI_WVALID,
    input  logic         i_wire_M_AXI_WREADY,
    input  logic         i_wire_M_AXI_BID,
    input  logic [1:0]   i_wire_M_AXI_BRESP,
    input  logic         i_wire_M_AXI_BVALID,
    output logic         o_wire_M_AXI_BREADY
);

    dma_state_t  state, next_state;
    logic [2:0]  error_type, next_error;
    logic [31:0] address, length, offset, new_offset;
    logic [1:0]  idx;
    logic [8:0]  burstlen, beat, awlen_full;
    logic [18:0] timeout;
    logic        awvalid;

    logic [31:0] sel_address, sel_length;
    logic [1:0]  sel_idx;
    logic        sel_ok;
    logic        aw_fire, w_fire, wlast, wvalid, handshake, timed_out, waiting;
    logic        unused_bid;

    always_comb begin
        sel_idx = 2'd0;
        sel_ok  = 1'b1;
        case (i_wire_router)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign sel_address = i_wire_address[32*sel_idx +: 32];
    assign sel_length  = i_wire_length[32*sel_idx +: 32];

    assign awlen_full = burstlen - 9'd1;
    assign wvalid     = (state == ST_DATA_WRITE) && i_wire_data_valid[idx];
    assign wlast      = (beat == awlen_full);
    assign aw_fire    = awvalid && i_wire_M_AXI_AWREADY;
    assign w_fire     = wvalid && i_wire_M_AXI_WREADY;
    assign new_offset = offset + {23'd0, burstlen};
    assign timed_out  = timeout[TIMEOUT_BIT];
    assign waiting    = (state == ST_ADDRESS_WRITE) || (state == ST_DATA_WRITE) ||
                        (state == ST_RESPONSE);

    always_comb begin
        handshake = 1'b0;
        case (state)
            ST_ADDRESS_WRITE: handshake = aw_fire;
            ST_DATA_WRITE:    handshake = w_fire;
            ST_RESPONSE:      handshake = i_wire_M_AXI_BVALID;
            default:          handshake = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        next_error = error_type;
        case (state)
            ST_ROUTING: begin
                if (sel_ok) begin
                    next_state = ST_PARAM_CHECK;
                end else begin
                    next_state = ST_ERROR;
                    next_error = ERR_ROUTER;
                end
            end
            ST_PARAM_CHECK: begin
                if (address[1:0] != 2'b00 || length == 32'd0) begin
                    next_state = ST_ERROR;
                    next_error = ERR_ADDRESS;
                end else begin
                    next_state = ST_CALC_ADDRESS;
                end
            end
            ST_CALC_ADDRESS: next_state = ST_ADDRESS_WRITE;
            ST_ADDRESS_WRITE: begin
                if (timed_out) begin
                    next_state = ST_ERROR;
                    next_error = ERR_AW_TIMEOUT;
                end else if (aw_fire) begin
                    next_state = ST_DATA_WRITE;
                end
            end
            ST_DATA_WRITE: begin
                if (timed_out) begin
                    next_state = ST_ERROR;
                    next_error = ERR_W_TIMEOUT;
                end else if (w_fire && wlast) begin
                    next_state = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                if (timed_out) begin
                    next_state = ST_ERROR;
                    next_error = ERR_B_TIMEOUT;
                end else if (i_wire_M_AXI_BVALID) begin
                    if (i_wire_M_AXI_BRESP != 2'b00) begin
                        next_state = ST_ERROR;
                        next_error = ERR_PROTOCOL;
                    end else if (new_offset >= length) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_CALC_ADDRESS;
                    end
                end
            end
            default: next_state = state;
        endcase
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state      <= ST_ROUTING;
            error_type <= ERR_NONE;
            address    <= '0;
            length     <= '0;
            offset     <= '0;
            idx        <= '0;
            burstlen   <= '0;
            beat       <= '0;
            timeout    <= '0;
            awvalid    <= 1'b0;
        end else begin
            state      <= next_state;
            error_type <= next_error;
            awvalid    <= (next_state == ST_ADDRESS_WRITE);
            case (state)
                ST_ROUTING: begin
                    if (sel_ok) begin
                        address <= sel_address;
                        length  <= sel_length;
                        idx     <= sel_idx;
                    end
                end
                ST_PARAM_CHECK: begin
                    offset  <= '0;
                    beat    <= '0;
                    timeout <= '0;
                end
                ST_CALC_ADDRESS: burstlen <= calc_burst(address, length, offset);
                ST_ADDRESS_WRITE: if (aw_fire) beat <= '0;
                ST_DATA_WRITE:    if (w_fire) beat <= beat + 9'd1;
                ST_RESPONSE: begin
                    if (i_wire_M_AXI_BVALID && i_wire_M_AXI_BRESP == 2'b00)
                        offset <= new_offset;
                end
                default: ;
            endcase
            // Stall watchdog: any handshake on the channel being waited on restarts it.
            if (waiting)
                timeout <= handshake ? 19'd0 : timeout + 19'd1;
        end
    end

    always_comb begin
        o_wire_data_next = 4'b0000;
        if (state == ST_DATA_WRITE)
            o_wire_data_next[idx] = i_wire_M_AXI_WREADY;
    end

    assign o_wire_done       = (state == ST_DONE);
    assign o_wire_error      = (state == ST_ERROR);
    assign o_wire_error_type = (state == ST_ERROR) ? error_type : ERR_NONE;

    assign o_wire_M_AXI_AWID    = 1'b0;
    assign o_wire_M_AXI_AWADDR  = address + {offset[29:0], 2'b00};
    assign o_wire_M_AXI_AWLEN   = awlen_full[7:0];
    assign o_wire_M_AXI_AWSIZE  = 3'b010;
    assign o_wire_M_AXI_AWBURST = 2'b01;
    assign o_wire_M_AXI_AWLOCK  = 1'b0;
    assign o_wire_M_AXI_AWCACHE = 4'b0010;
    assign o_wire_M_AXI_AWPROT  = 3'b000;
    assign o_wire_M_AXI_AWQOS   = 4'b0000;
    assign o_wire_M_AXI_AWVALID = awvalid;

    assign o_wire_M_AXI_WDATA  = i_wire_data[32*idx +: 32];
    assign o_wire_M_AXI_WSTRB  = 4'hF;
    assign o_wire_M_AXI_WLAST  = wlast;
    assign o_wire_M_AXI_WVALID = wvalid;

    assign o_wire_M_AXI_BREADY = (state == ST_RESPONSE);
    assign unused_bid          = i_wire_M_AXI_BID;

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// tb/tb_painterengine_gpu_dma_writer.sv - scoreboard bench for painterengine_gpu_dma_writer
module tb_painterengine_gpu_dma_writer;

    localparam int TB_TIMEOUT_BIT = 8;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } w_exp_t;

    typedef struct {
        string       name;
        logic [3:0]  router;
        logic [31:0] addr;
        logic [31:0] len;
        bit          rnd;
        bit          exp_done;
        logic [2:0]  exp_code;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] addr_bus = '0;
    logic [127:0] len_bus = '0;
    logic [3:0]   router = 4'b0001;
    logic [127:0] data_bus;
    logic [3:0]   data_valid = 4'hF;
    logic [3:0]   data_next;
    logic         done, error;
    logic [2:0]   error_type;
    logic         awid, awlock, awvalid, wlast, wvalid, bready;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst;
    logic [3:0]   awcache, awqos, wstrb;
    logic         awready = 1'b1;
    logic         wready = 1'b1;
    logic         bid = 1'b0;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b1;

    int      n_tests = 0;
    int      n_fail = 0;
    int      word_cnt = 0;
    bit      w_pending = 0;
    bit      rand_mode = 0;
    int      cur_slot = 0;
    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    aw_exp_t ae;
    w_exp_t  we;
    vec_t    vecs[8];

    painterengine_gpu_dma_writer #(.TIMEOUT_BIT(TB_TIMEOUT_BIT)) dut (
        .i_wire_clock         (clk),
        .i_wire_reset         (rst),
        .i_wire_address       (addr_bus),
        .i_wire_length        (len_bus),
        .i_wire_router        (router),
        .i_wire_data          (data_bus),
        .i_wire_data_valid    (data_valid),
        .o_wire_data_next     (data_next),
        .o_wire_done          (done),
        .o_wire_error         (error),
        .o_wire_error_type    (error_type),
        .o_wire_M_AXI_AWID    (awid),
        .o_wire_M_AXI_AWADDR  (awaddr),
        .o_wire_M_AXI_AWLEN   (awlen),
        .o_wire_M_AXI_AWSIZE  (awsize),
        .o_wire_M_AXI_AWBURST (awburst),
        .o_wire_M_AXI_AWLOCK  (awlock),
        .o_wire_M_AXI_AWCACHE (awcache),
        .o_wire_M_AXI_AWPROT  (awprot),
        .o_wire_M_AXI_AWQOS   (awqos),
        .o_wire_M_AXI_AWVALID (awvalid),
        .i_wire_M_AXI_AWREADY (awready),
        .o_wire_M_AXI_WDATA   (wdata),
        .o_wire_M_AXI_WSTRB   (wstrb),
        .o_wire_M_AXI_WLAST   (wlast),
        .o_wire_M_AXI_WVALID  (wvalid),
        .i_wire_M_AXI_WREADY  (wready),
        .i_wire_M_AXI_BID     (bid),
        .i_wire_M_AXI_BRESP   (bresp),
        .i_wire_M_AXI_BVALID  (bvalid),
        .o_wire_M_AXI_BREADY  (bready)
    );

    always #5 clk = ~clk;

    // Each slot carries a distinct tag in its top byte so a wrong slot mux shows up in WDATA.
    always_comb begin
        for (int k = 0; k < 4; k++)
            data_bus[32*k +: 32] = {8'hA0 + 8'(k), 24'(word_cnt)};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (awvalid && awready) begin
                if (aw_q.size() == 0) begin
                    check("aw_unexpected", 1, 0);
                end else begin
                    ae = aw_q.pop_front();
                    check("aw_addr", awaddr, ae.addr);
                    check("aw_len", {24'd0, awlen}, {24'd0, ae.len});
                end
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) begin
                    check("w_unexpected", 1, 0);
                end else begin
                    we = w_q.pop_front();
                    check("w_data", wdata, we.data);
                    check("w_last", {31'd0, wlast}, {31'd0, we.last});
                end
                w_pending = 1;
            end
            if (wvalid)
                check("data_next", {28'd0, data_next}, wready ? 32'(4'b0001 << cur_slot) : 32'd0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (w_pending) begin
            word_cnt++;
            w_pending = 0;
        end
        if (rand_mode) begin
            awready    = ($urandom_range(0, 3) != 0);
            wready     = ($urandom_range(0, 3) != 0);
            bvalid     = ($urandom_range(0, 2) != 0);
            data_valid = ($urandom_range(0, 3) != 0) ? 4'hF : 4'h0;
        end
    end

    // Independent burst model: walk the words, cutting at each 1 KB page end and at 256 beats.
    task automatic push_model(input logic [31:0] a, input logic [31:0] l, input int slot);
        logic [31:0] cur;
        int rem, to_page, n, k;
        cur = a;
        rem = int'(l);
        k = 0;
        while (rem > 0) begin
            to_page = (1024 - int'(cur % 1024)) / 4;
            n = (rem < to_page) ? rem : to_page;
            if (n > 256) n = 256;
            aw_q.push_back('{cur, 8'(n - 1)});
            for (int j = 0; j < n; j++) begin
                w_q.push_back('{{8'hA0 + 8'(slot), 24'(k)}, (j == n - 1)});
                k++;
            end
            cur = cur + 32'(4 * n);
            rem = rem - n;
        end
    endtask

    task automatic run_case(input string nm, input logic [3:0] rt, input logic [31:0] a,
                            input logic [31:0] l, input bit rnd, input bit exp_done,
                            input logic [2:0] exp_code, input bit chk_q);
        bit hit;
        int slot;
        @(posedge clk);
        #2;
        rst = 1;
        aw_q.delete();
        w_q.delete();
        word_cnt = 0;
        w_pending = 0;
        case (rt)
            4'b0010: slot = 1;
            4'b0100: slot = 2;
            4'b1000: slot = 3;
            default: slot = 0;
        endcase
        for (int k = 0; k < 4; k++) begin
            addr_bus[32*k +: 32] = 32'h0000_4004 + 32'(k);
            len_bus[32*k +: 32]  = 32'd7;
        end
        addr_bus[32*slot +: 32] = a;
        len_bus[32*slot +: 32]  = l;
        router = rt;
        cur_slot = slot;
        if (exp_done || exp_code == 3'b101 || (exp_code >= 3'b011 && exp_code != 3'b101))
            push_model(a, l, slot);
        @(posedge clk);
        #2;
        rst = 0;
        rand_mode = rnd;
        hit = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (done || error) begin
                hit = 1;
                break;
            end
        end
        rand_mode = 0;
        #1;
        awready = 1; wready = 1; bvalid = 1; data_valid = 4'hF;
        check({nm, "_finished"}, {31'd0, hit}, 32'd1);
        check({nm, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({nm, "_error"}, {31'd0, error}, {31'd0, !exp_done});
        check({nm, "_code"}, {29'd0, error_type}, {29'd0, exp_code});
        if (chk_q) begin
            check({nm, "_aw_left"}, aw_q.size(), 0);
            check({nm, "_w_left"}, w_q.size(), 0);
        end
        repeat (3) @(negedge clk);
        check({nm, "_terminal"}, {31'd0, done}, {31'd0, exp_done});
        check({nm, "_axi_idle"}, {29'd0, awvalid, wvalid, bready}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"r2_1000_len4",   4'b0010, 32'h0000_1000, 32'd4,   0, 1, 3'b000};
        vecs[1] = '{"r1_13f8_len10",  4'b0001, 32'h0000_13F8, 32'd10,  0, 1, 3'b000};
        vecs[2] = '{"r8_0_len600",    4'b1000, 32'h0000_0000, 32'd600, 1, 1, 3'b000};
        vecs[3] = '{"r4_3fc_len3",    4'b0100, 32'h0000_03FC, 32'd3,   1, 1, 3'b000};
        vecs[4] = '{"router3",        4'b0011, 32'h0000_1000, 32'd4,   0, 0, 3'b001};
        vecs[5] = '{"router0",        4'b0000, 32'h0000_1000, 32'd4,   0, 0, 3'b001};
        vecs[6] = '{"addr_1002",      4'b0001, 32'h0000_1002, 32'd4,   0, 0, 3'b010};
        vecs[7] = '{"len0",           4'b0001, 32'h0000_1000, 32'd0,   0, 0, 3'b010};

        repeat (3) @(negedge clk);
        check("rst_done", {31'd0, done}, 0);
        check("rst_error", {31'd0, error}, 0);
        check("rst_code", {29'd0, error_type}, 0);
        check("rst_valids", {29'd0, awvalid, wvalid, bready}, 0);
        check("rst_next", {28'd0, data_next}, 0);
        check("const_aw", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
              {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
        check("const_wstrb", {28'd0, wstrb}, 32'hF);

        for (int i = 0; i < 8; i++)
            run_case(vecs[i].name, vecs[i].router, vecs[i].addr, vecs[i].len,
                     vecs[i].rnd, vecs[i].exp_done, vecs[i].exp_code, 1);

        bresp = 2'b10;
        run_case("bresp_slverr", 4'b0001, 32'h0000_1000, 32'd4, 0, 0, 3'b101, 1);
        bresp = 2'b00;

        awready = 0;
        run_case("aw_timeout", 4'b0001, 32'h0000_1000, 32'd4, 0, 0, 3'b011, 0);
        wready = 0;
        run_case("w_timeout", 4'b0001, 32'h0000_1000, 32'd4, 0, 0, 3'b100, 0);
        bvalid = 0;
        run_case("b_timeout", 4'b0001, 32'h0000_1000, 32'd4, 0, 0, 3'b110, 1);

        // Reset landing while beat 3 is on the bus must drop every valid immediately.
        @(posedge clk);
        #2;
        rst = 1;
        aw_q.delete();
        w_q.delete();
        word_cnt = 0;
        w_pending = 0;
        router = 4'b0010;
        cur_slot = 1;
        addr_bus[63:32] = 32'h0000_1000;
        len_bus[63:32]  = 32'd8;
        push_model(32'h0000_1000, 32'd8, 1);
        @(posedge clk);
        #2;
        rst = 0;
        begin
            bit seen;
            seen = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (wvalid && word_cnt == 2) begin
                    seen = 1;
                    break;
                end
            end
            check("mid_reset_reached_beat3", {31'd0, seen}, 1);
        end
        #2;
        rst = 1;
        #1;
        check("mid_reset_valids", {29'd0, awvalid, wvalid, bready}, 0);
        check("mid_reset_next", {28'd0, data_next}, 0);
        check("mid_reset_done", {30'd0, done, error}, 0);
        run_case("after_reset_r1", 4'b0001, 32'h0000_2000, 32'd5, 0, 1, 3'b000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/painterengine_gpu_dma_writer.md
PAINTERENGINE_GPU_DMA_WRITER -- requirements
Module: painterengine_gpu_dma_writer

Interface
REQ-001 SHALL have parameter TIMEOUT_BIT, default 18: index of the stall-counter bit that raises a timeout.
REQ-002 SHALL have port i_wire_clock, in, 1: single clock; all logic on the rising edge.
REQ-003 SHALL have port i_wire_reset, in, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port i_wire_address, in, 4*32: four router-slot byte start addresses.
REQ-005 SHALL have port i_wire_length, in, 4*32: four router-slot lengths, in 32-bit words.
REQ-006 SHALL have port i_wire_router, in, 4: one-hot slot select.
REQ-007 SHALL have port i_wire_data, in, 4*32: per-slot write data.
REQ-008 SHALL have port i_wire_data_valid, in, 4: per-slot data valid.
REQ-009 SHALL have port o_wire_data_next, out, 4: per-slot data accept strobe.
REQ-010 SHALL have port o_wire_done, out, 1: transfer complete.
REQ-011 SHALL have ports o_wire_error, out, 1, and o_wire_error_type, out, 3: error flag and error code.
REQ-012 SHALL have AXI AW ports: o_wire_M_AXI_AWADDR out 32, AWLEN out 8, AWVALID out 1, i_wire_M_AXI_AWREADY in 1.
REQ-013 SHALL drive the remaining AW ports as constants: AWID 1-bit 0, AWSIZE 3'b010, AWBURST 2'b01, AWLOCK 0, AWCACHE 4'b0010, AWPROT 0, AWQOS 0.
REQ-014 SHALL have AXI W ports: o_wire_M_AXI_WDATA out 32, WSTRB out 4 (constant 4'hF), WLAST out 1, WVALID out 1, i_wire_M_AXI_WREADY in 1.
REQ-015 SHALL have AXI B ports: i_wire_M_AXI_BID in 1, BRESP in 2, BVALID in 1, o_wire_M_AXI_BREADY out 1.

Function
REQ-016 SHALL implement FSM states ROUTING 0, PARAM_CHECK 1, CALC_ADDRESS 2, ADDRESS_WRITE 3, DATA_WRITE 4, RESPONSE 5, DONE 6, ERROR 7.
REQ-017 SHALL handle routing in ROUTING: router 1/2/4/8 latches slot 0/1/2/3 address, length and index, then goes to PARAM_CHECK; any other value goes to ERROR with code 001 (router).
REQ-018 SHALL in PARAM_CHECK clear offset, beat counter and timeout; address[1:0]!=0 or length==0 goes to ERROR with code 010 (address); otherwise goes to CALC_ADDRESS.
REQ-019 SHALL in CALC_ADDRESS compute remaining = length-offset and boundary = 256-(address[9:2]+offset[7:0]) in 8-bit wrap, 9-bit result; burstlen = min(boundary, remaining), then go to ADDRESS_WRITE.
REQ-020 SHALL in ADDRESS_WRITE present AWADDR = address+offset*4, AWLEN = burstlen-1, AWVALID=1; on AWVALID&AWREADY clear AWVALID and the beat counter and go to DATA_WRITE.
REQ-021 SHALL in DATA_WRITE set WVALID = i_wire_data_valid[idx], WDATA = slot data, o_wire_data_next[idx] = WREADY; all other next bits SHALL be 0, and all next bits SHALL be 0 outside DATA_WRITE.
REQ-022 SHALL assert WLAST when the beat counter equals burstlen-1; a beat SHALL count on WVALID&WREADY; the WLAST beat SHALL go to RESPONSE.
REQ-023 SHALL assert BREADY only in RESPONSE; on BVALID with BRESP==00, offset += burstlen, then go to DONE if the new offset is >= length, otherwise to CALC_ADDRESS.
REQ-024 SHALL treat BVALID with BRESP!=00 as ERROR with code 101 (protocol).
REQ-025 SHALL, in states 3/4/5, increment the 19-bit timeout counter on every cycle without a handshake and clear it on a handshake; when bit TIMEOUT_BIT sets, go to ERROR with code 011/100/110 respectively.
REQ-026 SHALL make DONE and ERROR terminal until reset; o_wire_done=(state==DONE), o_wire_error=(state==ERROR); code 000 when not in error.
REQ-027 SHALL never let a burst cross a 1 KB boundary or exceed 256 beats.

Reset
REQ-028 SHALL on i_wire_reset=1, immediately and asynchronously: state ROUTING, all counters, address/length/offset/index 0, AWVALID 0, error_type 000.
REQ-029 SHALL let reset asserted mid-burst abandon the transfer; no AXI valid SHALL remain asserted.

Structure
REQ-030 SHALL place FSM state codes and error codes in a shared package painterengine_gpu_dma_pkg, also used by the reader.
REQ-031 SHALL use a single module with no sub-modules; the slot mux is inline combinational logic.

Verification
REQ-032 SHALL cover: router=2, addr 0x1000, len 4, AWREADY/WREADY/BVALID always 1 -> one AW (addr 0x1000, AWLEN 3), 4 beats with WLAST on beat 4, done.
REQ-033 SHALL cover: addr 0x13F8, len 10 -> bursts (0x13F8, AWLEN 1) then (0x1400, AWLEN 7).
REQ-034 SHALL cover: len 600, addr 0 -> AWLENs 255, 255, 87.
REQ-035 SHALL cover: router=3 -> error, code 001; addr 0x1002 -> error, code 010.
REQ-036 SHALL cover: BRESP=10 -> error, code 101; WREADY held 0 for 2^18 cycles -> code 100.
REQ-037 SHALL cover: reset asserted during beat 3 -> AWVALID/WVALID/BREADY 0 the same cycle; a new router=1 transfer then completes.
